// File: rtl/free_list_pkg.sv
// Shared definitions for the rename-stage free list.
//   ROB_DEPTH : ROB entries and free-list capacity (power of 2, >= 4)
//   PREG_W    : physical-register index width (ROB_DEPTH + 32 registers)
//   PTR_W     : free-list pointer width, index bits plus one wrap bit
//   IDX_W     : pointer index width (no wrap bit)
package free_list_pkg;

  localparam int ROB_DEPTH = 32;
  localparam int PREG_W    = $clog2(ROB_DEPTH + 32);
  localparam int PTR_W     = $clog2(ROB_DEPTH) + 1;
  localparam int IDX_W     = PTR_W - 1;

  typedef logic [PREG_W-1:0] preg_t;
  typedef logic [PTR_W-1:0]  fl_ptr_t;

endpackage : free_list_pkg

// File: rtl/free_list.sv
// Circular FIFO of free physical-register indices feeding rename.
// The commit side pushes displaced registers back; rename pops one new
// destination per cycle. A flush makes every register not held by the
// retirement map free again in one cycle by moving the head pointer.
//
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   flush         : mispredict/exception recovery
//   kick_valid    : push request from commit
//   kick_p_addr   : physical register being freed
//   alloc_req     : pop request from rename
//   alloc_valid   : head entry available (list not empty)
//   alloc_p_addr  : head entry, meaningful only with alloc_valid
//   free_count    : number of entries held
//   full          : free_count == ROB_DEPTH
//   overflow_err  : sticky, push attempted while full (cleared by rst)
module free_list
  import free_list_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              kick_valid,
  input  logic [PREG_W-1:0] kick_p_addr,
  input  logic              alloc_req,
  output logic              alloc_valid,
  output logic [PREG_W-1:0] alloc_p_addr,
  output logic [PTR_W-1:0]  free_count,
  output logic              full,
  output logic              overflow_err
);

  preg_t   mem_q [ROB_DEPTH];
  fl_ptr_t rd_ptr_q, rd_ptr_d;
  fl_ptr_t wr_ptr_q, wr_ptr_d;
  logic    overflow_q, overflow_d;

  logic empty;
  logic push;
  logic pop;

  assign empty = (rd_ptr_q == wr_ptr_q);
  assign full  = (rd_ptr_q[IDX_W-1:0] == wr_ptr_q[IDX_W-1:0]) &&
                 (rd_ptr_q[IDX_W] != wr_ptr_q[IDX_W]);

  // Decisions use pre-edge full/empty: a full list rejects a push even
  // when a pop frees a slot this cycle, and an empty list has no bypass.
  assign push = kick_valid && !full;
  assign pop  = alloc_req && !empty && !flush;

  always_comb begin
    overflow_d = overflow_q || (kick_valid && full);
    wr_ptr_d   = wr_ptr_q + fl_ptr_t'(push);
    rd_ptr_d   = rd_ptr_q + fl_ptr_t'(pop);
    // Flush: the slots between tail and head hold exactly the in-flight
    // allocations, so placing the head one lap behind the (post-push)
    // tail returns all of them at once.
    if (flush) begin
      rd_ptr_d = {~wr_ptr_d[IDX_W], wr_ptr_d[IDX_W-1:0]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= {1'b1, {IDX_W{1'b0}}};
      overflow_q <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage reset fills the list with registers 32..32+ROB_DEPTH-1, the
  // ones not mapped by the initial architectural state.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ROB_DEPTH; i++) begin
        mem_q[i] <= preg_t'(32 + i);
      end
    end else if (push) begin
      mem_q[wr_ptr_q[IDX_W-1:0]] <= kick_p_addr;
    end
  end

  assign alloc_valid  = !empty;
  assign alloc_p_addr = mem_q[rd_ptr_q[IDX_W-1:0]];
  assign free_count   = wr_ptr_q - rd_ptr_q;
  assign overflow_err = overflow_q;

`ifndef SYNTHESIS
  // A kick while full must leave the tail untouched.
  a_no_push_full : assert property (@(posedge clk) disable iff (rst)
    (kick_valid && full) |=> (wr_ptr_q == $past(wr_ptr_q)));

  a_kick_range : assert property (@(posedge clk) disable iff (rst)
    kick_valid |-> (int'(kick_p_addr) < ROB_DEPTH + 32));

  a_count_range : assert property (@(posedge clk) disable iff (rst)
    int'(free_count) <= ROB_DEPTH);
`endif

endmodule : free_list

// File: tb/tb_free_list.sv
// Directed bench for free_list: reset contents, drain, push/pop latency,
// flush restore (with and without a same-cycle kick), overflow, and a
// randomized pop-one/push-one run checked against a queue model.
module tb_free_list;
  import free_list_pkg::*;

  logic              clk;
  logic              rst;
  logic              flush;
  logic              kick_valid;
  logic [PREG_W-1:0] kick_p_addr;
  logic              alloc_req;
  logic              alloc_valid;
  logic [PREG_W-1:0] alloc_p_addr;
  logic [PTR_W-1:0]  free_count;
  logic              full;
  logic              overflow_err;

  int n_checks = 0;
  int n_passed = 0;

  free_list dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .kick_valid   (kick_valid),
    .kick_p_addr  (kick_p_addr),
    .alloc_req    (alloc_req),
    .alloc_valid  (alloc_valid),
    .alloc_p_addr (alloc_p_addr),
    .free_count   (free_count),
    .full         (full),
    .overflow_err (overflow_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // One clock: inputs were set after the previous edge; outputs are
  // sampled 1 time unit after this edge.
  task automatic tick();
    $display("txn t=%0t rst=%0b flush=%0b kick=%0b/%0d req=%0b | valid=%0b head=%0d cnt=%0d full=%0b ovf=%0b",
             $time, rst, flush, kick_valid, kick_p_addr, alloc_req,
             alloc_valid, alloc_p_addr, free_count, full, overflow_err);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 1'b0; flush = 1'b0; kick_valid = 1'b0; kick_p_addr = '0; alloc_req = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic pop_expect(input string tag, input int exp);
    chk({tag, "_valid"}, 32'(alloc_valid), 1);
    chk(tag, 32'(alloc_p_addr), 32'(exp));
    alloc_req = 1'b1;
    tick();
    alloc_req = 1'b0;
  endtask

  initial begin
    preg_t model_q[$];
    preg_t v;

    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    chk("rst_valid", 32'(alloc_valid), 1);
    chk("rst_head",  32'(alloc_p_addr), 32);
    chk("rst_count", 32'(free_count), 32);
    chk("rst_full",  32'(full), 1);
    chk("rst_ovf",   32'(overflow_err), 0);

    // Drain all reset contents in order
    for (int i = 0; i < 32; i++) pop_expect("drain", 32 + i);
    chk("drained_valid", 32'(alloc_valid), 0);
    chk("drained_count", 32'(free_count), 0);
    chk("drained_full",  32'(full), 0);

    // Pop while empty: no change, no error
    alloc_req = 1'b1;
    tick();
    alloc_req = 1'b0;
    chk("empty_pop_count", 32'(free_count), 0);
    chk("empty_pop_ovf",   32'(overflow_err), 0);

    // Push 5 then 9; entry poppable the cycle after its push
    kick_valid = 1'b1; kick_p_addr = 6'd5;
    tick();
    chk("push5_valid", 32'(alloc_valid), 1);
    chk("push5_head",  32'(alloc_p_addr), 5);
    chk("push5_count", 32'(free_count), 1);
    kick_p_addr = 6'd9;
    tick();
    kick_valid = 1'b0;
    chk("push9_head",  32'(alloc_p_addr), 5);
    chk("push9_count", 32'(free_count), 2);
    pop_expect("pop5", 5);
    pop_expect("pop9", 9);
    chk("re_empty_valid", 32'(alloc_valid), 0);

    // Empty with push+pop: pop not granted, value visible next cycle
    kick_valid = 1'b1; kick_p_addr = 6'd11; alloc_req = 1'b1;
    tick();
    idle();
    chk("nobypass_count", 32'(free_count), 1);
    chk("nobypass_head",  32'(alloc_p_addr), 11);
    pop_expect("pop11", 11);

    // Pop 3, push 7, flush -> full again, head one past the pushed slot
    do_reset();
    pop_expect("p3a", 32);
    pop_expect("p3b", 33);
    pop_expect("p3c", 34);
    kick_valid = 1'b1; kick_p_addr = 6'd7;
    tick();
    kick_valid = 1'b0;
    chk("pre_flush_count", 32'(free_count), 30);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_count", 32'(free_count), 32);
    chk("flush_full",  32'(full), 1);
    chk("flush_head",  32'(alloc_p_addr), 33);

    // Kick while full: dropped, sticky overflow
    kick_valid = 1'b1; kick_p_addr = 6'd40;
    tick();
    kick_valid = 1'b0;
    chk("ovf_set",   32'(overflow_err), 1);
    chk("ovf_count", 32'(free_count), 32);
    chk("ovf_head",  32'(alloc_p_addr), 33);

    // Full with pop+push: pop taken, push rejected
    kick_valid = 1'b1; kick_p_addr = 6'd41; alloc_req = 1'b1;
    tick();
    idle();
    chk("fullpp_count", 32'(free_count), 31);
    chk("fullpp_head",  32'(alloc_p_addr), 34);
    chk("ovf_sticky",   32'(overflow_err), 1);

    // Not full with pop+push: count unchanged, 42 lands in vacated slot
    kick_valid = 1'b1; kick_p_addr = 6'd42; alloc_req = 1'b1;
    tick();
    idle();
    chk("pp_count", 32'(free_count), 31);
    chk("pp_head",  32'(alloc_p_addr), 35);
    for (int i = 35; i < 64; i++) pop_expect("after_flush", i);
    pop_expect("after_flush_7", 7);
    pop_expect("after_flush_42", 42);
    chk("after_flush_empty", 32'(alloc_valid), 0);
    chk("ovf_still", 32'(overflow_err), 1);

    // Flush + kick(12) with 10 held; the same-cycle pop request is ignored
    do_reset();
    chk("ovf_cleared", 32'(overflow_err), 0);
    for (int i = 0; i < 22; i++) pop_expect("pre22", 32 + i);
    chk("held10", 32'(free_count), 10);
    flush = 1'b1; kick_valid = 1'b1; kick_p_addr = 6'd12; alloc_req = 1'b1;
    tick();
    idle();
    chk("fk_full",  32'(full), 1);
    chk("fk_count", 32'(free_count), 32);
    chk("fk_head",  32'(alloc_p_addr), 33);
    for (int i = 33; i < 64; i++) pop_expect("fk_drain", i);
    pop_expect("fk_12", 12);
    chk("fk_empty", 32'(alloc_valid), 0);

    // Steady pop-one/push-one at count 16 against a queue model
    do_reset();
    for (int i = 0; i < 32; i++) model_q.push_back(preg_t'(32 + i));
    for (int i = 0; i < 16; i++) begin
      pop_expect("to16", int'(model_q[0]));
      void'(model_q.pop_front());
    end
    for (int i = 0; i < 100; i++) begin
      v = preg_t'($urandom_range(0, 63));
      chk("wrap_head", 32'(alloc_p_addr), 32'(model_q[0]));
      alloc_req = 1'b1; kick_valid = 1'b1; kick_p_addr = v;
      tick();
      void'(model_q.pop_front());
      model_q.push_back(v);
      chk("wrap_count", 32'(free_count), 16);
    end
    idle();

    // Reset mid-operation restores reset contents
    rst = 1'b1; alloc_req = 1'b1; kick_valid = 1'b1; kick_p_addr = 6'd3; flush = 1'b1;
    tick();
    idle();
    chk("rst2_head",  32'(alloc_p_addr), 32);
    chk("rst2_count", 32'(free_count), 32);
    chk("rst2_full",  32'(full), 1);
    chk("rst2_ovf",   32'(overflow_err), 0);
    pop_expect("rst2_pop", 32);
    chk("rst2_next", 32'(alloc_p_addr), 33);

    $display("%0d/%0d checks passed", n_passed, n_checks);
    $finish;
  end

endmodule : tb_free_list
